// File: rtl/csc_spad_pkg.sv
// Shared definitions for the double-buffered CSC data scratchpad.
// Holds the default field widths, the terminator word and the bank index type.
package csc_spad_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 4;
  localparam int DEPTH_DEF  = 100;
  localparam int WORD_W_DEF = DATA_W_DEF + CNT_W_DEF;

  // An all-zero {data, count} word ends a column list.
  localparam logic [WORD_W_DEF-1:0] TERM_WORD = '0;

  typedef enum logic {
    BANK0 = 1'b0,
    BANK1 = 1'b1
  } bank_t;

  function automatic bank_t other_bank(input bank_t b);
    return (b == BANK0) ? BANK1 : BANK0;
  endfunction

endpackage

// File: rtl/csc_pingpong_data_spad_if.sv
// Fill-side and read-side signal bundle of the ping-pong CSC scratchpad.
// The slave modport is the scratchpad; the master modport is the decoder/MAC side.
interface csc_pingpong_data_spad_if
  import csc_spad_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int WORD_W = DATA_W + CNT_W;

  logic              data_in_valid;
  logic              data_in_ready;
  logic [WORD_W-1:0] data_in;
  logic              write_en;
  logic              write_fin;
  logic              read_en;
  logic              read_idx_en;
  logic [ADDR_W-1:0] read_idx;
  logic              index_inc;
  logic              read_release;
  logic              rd_bank_valid;
  logic [WORD_W-1:0] data_out;
  logic [ADDR_W-1:0] column_num;
  logic              overflow;

  modport slave (
    input  data_in_valid, data_in, write_en,
    input  read_en, read_idx_en, read_idx, index_inc, read_release,
    output data_in_ready, write_fin, rd_bank_valid, data_out, column_num, overflow
  );

  modport master (
    output data_in_valid, data_in, write_en,
    output read_en, read_idx_en, read_idx, index_inc, read_release,
    input  data_in_ready, write_fin, rd_bank_valid, data_out, column_num, overflow
  );

endinterface

// File: rtl/csc_spad_ram.sv
// Two-bank word store: one write port, one synchronous read port, no reset.
// Address is {bank, column}; rows past DEPTH in each bank are never touched.
module csc_spad_ram #(
  parameter int WORD_W = 12,
  parameter int ADDR_W = 7
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [ADDR_W:0]   waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [ADDR_W:0]   raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  localparam int ROWS = 1 << (ADDR_W + 1);

  logic [WORD_W-1:0] mem [ROWS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/csc_pingpong_data_spad.sv
// Double-buffered CSC {data, count} scratchpad: the decoder fills one bank while
// the MAC side reads the other; banks swap on commit/release handshakes.
module csc_pingpong_data_spad
  import csc_spad_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  csc_pingpong_data_spad_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int WORD_W = DATA_W + CNT_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [WORD_W-1:0] TERM     = WORD_W'(TERM_WORD);

  logic [1:0]        bank_full_q, bank_full_d;
  bank_t             wr_sel_q, wr_sel_d;
  bank_t             rd_sel_q, rd_sel_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] column_q, column_d;
  logic              overflow_q, overflow_d;

  logic              ready;
  logic              shake;
  logic              is_term;
  logic              wr_last;
  logic              commit;
  logic              release_ok;
  logic              rd_valid;
  logic [WORD_W-1:0] ram_rdata;
  logic [WORD_W-1:0] rd_word;

  assign ready      = !bank_full_q[wr_sel_q] && (int'(wr_ptr_q) < DEPTH);
  assign shake      = bus.data_in_valid && ready && bus.write_en;
  assign is_term    = (bus.data_in == TERM);
  assign wr_last    = (wr_ptr_q == LAST_ADDR);
  assign commit     = shake && (is_term || wr_last);
  assign rd_valid   = bank_full_q[rd_sel_q];
  assign release_ok = bus.read_release && rd_valid;

  // A bank that is not committed always reads as a terminator.
  assign rd_word    = rd_valid ? ram_rdata : TERM;

  always_comb begin
    bank_full_d = bank_full_q;
    wr_sel_d    = wr_sel_q;
    wr_ptr_d    = wr_ptr_q;
    overflow_d  = overflow_q;
    if (shake) begin
      if (commit) begin
        bank_full_d[wr_sel_q] = 1'b1;
        wr_sel_d              = other_bank(wr_sel_q);
        wr_ptr_d              = '0;
      end else begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (wr_last && !is_term) begin
        overflow_d = 1'b1;
      end
    end
    // Commit needs an empty bank and release a full one, so these never collide.
    rd_sel_d = rd_sel_q;
    if (release_ok) begin
      bank_full_d[rd_sel_q] = 1'b0;
      rd_sel_d              = other_bank(rd_sel_q);
    end
  end

  always_comb begin
    column_d = column_q;
    if (release_ok) begin
      column_d = '0;
    end else if (bus.read_idx_en) begin
      column_d = bus.read_idx;
    end else if (bus.index_inc) begin
      if (rd_word == TERM || column_q == LAST_ADDR) begin
        column_d = '0;
      end else begin
        column_d = column_q + ADDR_W'(1);
      end
    end
  end

  assign rd_addr_d = bus.read_en ? column_q : rd_addr_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bank_full_q <= '0;
      wr_sel_q    <= BANK0;
      rd_sel_q    <= BANK0;
      wr_ptr_q    <= '0;
      rd_addr_q   <= '0;
      column_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      bank_full_q <= bank_full_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_addr_q   <= rd_addr_d;
      column_q    <= column_d;
      overflow_q  <= overflow_d;
    end
  end

  csc_spad_ram #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .we_i    (shake),
    .waddr_i ({wr_sel_q, wr_ptr_q}),
    .wdata_i (bus.data_in),
    .raddr_i ({rd_sel_q, rd_addr_d}),
    .rdata_o (ram_rdata)
  );

  assign bus.data_in_ready = ready;
  assign bus.write_fin     = commit;
  assign bus.rd_bank_valid = rd_valid;
  assign bus.data_out      = rd_word;
  assign bus.column_num    = column_q;
  assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_csc_pingpong_data_spad.sv
// Directed bench for the ping-pong CSC scratchpad: fill/read overlap, stall on
// both banks full, overflow, column priority and async reset.
module tb_csc_pingpong_data_spad;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  csc_pingpong_data_spad_if bus ();

  csc_pingpong_data_spad dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.data_in_valid = 1'b0;
    bus.data_in       = '0;
    bus.write_en      = 1'b0;
    bus.read_en       = 1'b0;
    bus.read_idx_en   = 1'b0;
    bus.read_idx      = '0;
    bus.index_inc     = 1'b0;
    bus.read_release  = 1'b0;
  endtask

  // One accepted write; the fill bank must be ready and write_fin as given.
  task automatic wr(input string tag, input logic [11:0] word, input logic fin_exp);
    bus.data_in       = word;
    bus.data_in_valid = 1'b1;
    bus.write_en      = 1'b1;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(bus.data_in_ready), 32'd1);
    chk({tag, "_fin"}, 32'(bus.write_fin), 32'(fin_exp));
    tick();
    bus.data_in_valid = 1'b0;
    bus.write_en      = 1'b0;
    bus.data_in       = '0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.data_in_ready), 32'd1);
    chk("rst_rdvalid", 32'(bus.rd_bank_valid), 32'd0);
    chk("rst_dout", 32'(bus.data_out), 32'h000);
    chk("rst_col", 32'(bus.column_num), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;
    tick();

    // Tile A into bank0
    wr("a0", 12'h051, 1'b0);
    wr("a1", 12'hFB3, 1'b0);
    wr("a2", 12'h000, 1'b1);
    chk("a_rdvalid", 32'(bus.rd_bank_valid), 32'd1);
    chk("a_ready_b1", 32'(bus.data_in_ready), 32'd1);

    bus.read_en = 1'b1;
    tick();
    chk("a_rd0", 32'(bus.data_out), 32'h051);
    bus.index_inc = 1'b1;
    tick();
    chk("a_rd0b", 32'(bus.data_out), 32'h051);
    chk("a_col1", 32'(bus.column_num), 32'd1);
    tick();
    chk("a_rd1", 32'(bus.data_out), 32'hFB3);
    tick();
    chk("a_rd2", 32'(bus.data_out), 32'h000);
    tick();
    chk("a_col_wrap0", 32'(bus.column_num), 32'd0);
    bus.index_inc = 1'b0;
    bus.read_en   = 1'b0;

    // Tile B fills bank1 while bank0 is re-read
    bus.read_idx_en = 1'b1;
    bus.read_idx    = 7'd1;
    wr("b0", 12'h7A2, 1'b0);
    bus.read_idx_en = 1'b0;
    chk("b_col_load", 32'(bus.column_num), 32'd1);
    bus.read_en = 1'b1;
    wr("b1", 12'h000, 1'b1);
    chk("b_rd_a1", 32'(bus.data_out), 32'hFB3);

    // Third tile stalls while both banks are full
    bus.data_in       = 12'h113;
    bus.data_in_valid = 1'b1;
    bus.write_en      = 1'b1;
    @(negedge clk);
    chk("c_stall_ready", 32'(bus.data_in_ready), 32'd0);
    chk("c_stall_fin", 32'(bus.write_fin), 32'd0);
    tick();
    bus.read_en      = 1'b0;
    bus.read_release = 1'b1;
    @(negedge clk);
    chk("c_stall_ready2", 32'(bus.data_in_ready), 32'd0);
    tick();
    bus.read_release = 1'b0;
    chk("c_rel_ready", 32'(bus.data_in_ready), 32'd1);
    chk("c_rel_rdvalid", 32'(bus.rd_bank_valid), 32'd1);
    chk("c_rel_col", 32'(bus.column_num), 32'd0);
    bus.read_en = 1'b1;
    @(negedge clk);
    chk("c0_fin", 32'(bus.write_fin), 32'd0);
    tick();
    chk("c_rd_b0", 32'(bus.data_out), 32'h7A2);
    bus.data_in = 12'h000;
    @(negedge clk);
    chk("c1_fin", 32'(bus.write_fin), 32'd1);
    tick();
    bus.data_in_valid = 1'b0;
    bus.write_en      = 1'b0;
    bus.read_en       = 1'b0;
    chk("c_full_ready", 32'(bus.data_in_ready), 32'd0);
    bus.read_release = 1'b1;
    tick();
    bus.read_release = 1'b0;
    chk("c_rel2_ready", 32'(bus.data_in_ready), 32'd1);
    bus.read_en = 1'b1;
    tick();
    chk("c_rd_c0", 32'(bus.data_out), 32'h113);
    bus.read_en      = 1'b0;
    bus.read_release = 1'b1;
    tick();
    bus.read_release = 1'b0;
    chk("c_empty_rdvalid", 32'(bus.rd_bank_valid), 32'd0);
    chk("c_empty_dout", 32'(bus.data_out), 32'h000);

    // 100 non-zero words into bank1: forced terminator and sticky overflow
    for (int i = 0; i < 100; i++) begin
      wr("ovf", {8'(i + 1), 4'h1}, (i == 99) ? 1'b1 : 1'b0);
    end
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    chk("ovf_rdvalid", 32'(bus.rd_bank_valid), 32'd1);
    chk("ovf_ready", 32'(bus.data_in_ready), 32'd1);
    bus.read_idx_en = 1'b1;
    bus.read_idx    = 7'd99;
    tick();
    bus.read_idx_en = 1'b0;
    chk("ovf_col99", 32'(bus.column_num), 32'd99);
    bus.read_en = 1'b1;
    tick();
    bus.read_en = 1'b0;
    chk("ovf_rd99", 32'(bus.data_out), 32'h641);
    bus.index_inc = 1'b1;
    tick();
    bus.index_inc = 1'b0;
    chk("ovf_col_wrap", 32'(bus.column_num), 32'd0);
    bus.read_release = 1'b1;
    tick();
    bus.read_release = 1'b0;
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    chk("ovf_rel_rdvalid", 32'(bus.rd_bank_valid), 32'd0);

    // Column priority: load beats increment, release beats load
    wr("p0", 12'h0A1, 1'b0);
    wr("p1", 12'h0B2, 1'b0);
    wr("p2", 12'h000, 1'b1);
    bus.read_idx_en = 1'b1;
    bus.read_idx    = 7'd2;
    bus.index_inc   = 1'b1;
    tick();
    bus.index_inc = 1'b0;
    chk("p_load_wins", 32'(bus.column_num), 32'd2);
    bus.read_idx     = 7'd5;
    bus.read_release = 1'b1;
    tick();
    bus.read_release = 1'b0;
    bus.read_idx_en  = 1'b0;
    chk("p_rel_wins", 32'(bus.column_num), 32'd0);
    chk("p_rel_swap", 32'(bus.rd_bank_valid), 32'd0);

    // Async reset mid-fill with one bank committed
    wr("r0", 12'h0C1, 1'b0);
    wr("r1", 12'h000, 1'b1);
    chk("r_pre_rdvalid", 32'(bus.rd_bank_valid), 32'd1);
    wr("r2", 12'h0D1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("r_rdvalid", 32'(bus.rd_bank_valid), 32'd0);
    chk("r_dout", 32'(bus.data_out), 32'h000);
    chk("r_ovf", 32'(bus.overflow), 32'd0);
    chk("r_col", 32'(bus.column_num), 32'd0);
    chk("r_ready", 32'(bus.data_in_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    bus.read_en = 1'b1;
    tick();
    tick();
    bus.read_en = 1'b0;
    chk("r_read_after", 32'(bus.data_out), 32'h000);
    chk("r_rdvalid_after", 32'(bus.rd_bank_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
